// File: rtl/calc_logic_param.sv
// calc_logic_param: parametrised hex calculator core with add, subtract and shift-add multiply.
// Optional backspace on keycode 5'h15 is built only when CALC_BACKSPACE_EN is defined.
module calc_logic_param #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = WIDTH / 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       keycode,
    input  logic             newkey,
    output logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             overflow,
    output logic             key_dropped
);
    localparam int DCW = $clog2(DIGITS + 1);
    localparam int MCW = $clog2(WIDTH);

    localparam logic [4:0] K_ADD = 5'h10;
    localparam logic [4:0] K_SUB = 5'h11;
    localparam logic [4:0] K_MUL = 5'h12;
    localparam logic [4:0] K_EQ  = 5'h13;
    localparam logic [4:0] K_CLR = 5'h14;
`ifdef CALC_BACKSPACE_EN
    localparam logic [4:0] K_BS  = 5'h15;
`endif

    typedef enum logic [1:0] {ST_FRESH = 2'd0, ST_ENTER = 2'd1, ST_MULBUSY = 2'd2} state_t;
    typedef enum logic [1:0] {OP_NONE = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2, OP_MUL = 2'd3} op_t;

    state_t             state_r, state_s;
    op_t                pend_op_r, pend_op_s, new_op_s;
    logic [WIDTH-1:0]   acc_r, acc_s, entry_r, entry_s, value_r, value_s;
    logic [DCW-1:0]     dcount_r, dcount_s;
    logic               busy_r, busy_s, ovf_r, ovf_s, kd_r, kd_s;
    logic [2*WIDTH-1:0] mcand_r, mcand_s, prod_r, prod_s, prod_step_s;
    logic [WIDTH-1:0]   mplier_r, mplier_s;
    logic [MCW-1:0]     mcount_r, mcount_s;
    logic [WIDTH:0]     sum_s;
    logic               key_digit_s, key_op_s, key_clear_s;
    logic               do_compute_s, start_mul_s, mul_done_s;
`ifdef CALC_BACKSPACE_EN
    logic               key_bs_s;
    assign key_bs_s = newkey & (keycode == K_BS);
`endif

    assign key_digit_s  = newkey & ~keycode[4];
    assign key_clear_s  = newkey & (keycode == K_CLR);
    assign key_op_s     = newkey & ((keycode == K_ADD) | (keycode == K_SUB) |
                                    (keycode == K_MUL) | (keycode == K_EQ));
    // In FRESH only EQUALS with a pending op computes, using the (zero) entry.
    assign do_compute_s = (state_r == ST_ENTER) | ((keycode == K_EQ) & (pend_op_r != OP_NONE));
    assign start_mul_s  = key_op_s & do_compute_s & (pend_op_r == OP_MUL) & (state_r != ST_MULBUSY);
    assign mul_done_s   = (state_r == ST_MULBUSY) & (mcount_r == MCW'(WIDTH - 1));
    assign sum_s        = {1'b0, acc_r} + {1'b0, entry_r};
    assign prod_step_s  = prod_r + (mplier_r[0] ? mcand_r : {(2 * WIDTH){1'b0}});

    assign value       = value_r;
    assign busy        = busy_r;
    assign overflow    = ovf_r;
    assign key_dropped = kd_r;

    // Operator keycode to pending-op encoding.
    always_comb begin
        case (keycode)
            K_ADD:   new_op_s = OP_ADD;
            K_SUB:   new_op_s = OP_SUB;
            K_MUL:   new_op_s = OP_MUL;
            default: new_op_s = OP_NONE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_FRESH;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_FRESH: begin
                if (key_clear_s)      state_s = ST_FRESH;
                else if (key_digit_s) state_s = ST_ENTER;
                else if (start_mul_s) state_s = ST_MULBUSY;
                else                  state_s = ST_FRESH;
            end
            ST_ENTER: begin
                if (key_clear_s)      state_s = ST_FRESH;
                else if (key_digit_s) state_s = ST_ENTER;
                else if (key_op_s)    state_s = start_mul_s ? ST_MULBUSY : ST_FRESH;
`ifdef CALC_BACKSPACE_EN
                else if (key_bs_s)    state_s = (dcount_r == DCW'(1)) ? ST_FRESH : ST_ENTER;
`endif
                else                  state_s = ST_ENTER;
            end
            ST_MULBUSY: begin
                if (key_clear_s || mul_done_s) state_s = ST_FRESH;
                else                           state_s = ST_MULBUSY;
            end
            default: state_s = ST_FRESH;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        acc_s     = acc_r;
        entry_s   = entry_r;
        pend_op_s = pend_op_r;
        dcount_s  = dcount_r;
        value_s   = value_r;
        busy_s    = busy_r;
        ovf_s     = ovf_r;
        kd_s      = 1'b0;
        mcand_s   = mcand_r;
        mplier_s  = mplier_r;
        prod_s    = prod_r;
        mcount_s  = mcount_r;
        if (key_clear_s) begin
            acc_s     = {WIDTH{1'b0}};
            entry_s   = {WIDTH{1'b0}};
            pend_op_s = OP_NONE;
            dcount_s  = {DCW{1'b0}};
            value_s   = {WIDTH{1'b0}};
            busy_s    = 1'b0;
            ovf_s     = 1'b0;
            mcand_s   = {(2 * WIDTH){1'b0}};
            mplier_s  = {WIDTH{1'b0}};
            prod_s    = {(2 * WIDTH){1'b0}};
            mcount_s  = {MCW{1'b0}};
        end else if (state_r == ST_MULBUSY) begin
            // One multiplier bit per cycle; any other key is dropped.
            mcand_s  = mcand_r << 1'b1;
            mplier_s = mplier_r >> 1'b1;
            prod_s   = prod_step_s;
            mcount_s = mcount_r + MCW'(1);
            kd_s     = newkey;
            if (mul_done_s) begin
                acc_s   = prod_step_s[WIDTH-1:0];
                value_s = prod_step_s[WIDTH-1:0];
                ovf_s   = ovf_r | (|prod_step_s[2*WIDTH-1:WIDTH]);
                busy_s  = 1'b0;
            end else begin
                busy_s  = 1'b1;
            end
        end else if (key_digit_s) begin
            if (state_r == ST_FRESH) begin
                entry_s  = {{(WIDTH - 4){1'b0}}, keycode[3:0]};
                value_s  = {{(WIDTH - 4){1'b0}}, keycode[3:0]};
                dcount_s = DCW'(1);
            end else if (dcount_r < DCW'(DIGITS)) begin
                entry_s  = {entry_r[WIDTH-5:0], keycode[3:0]};
                value_s  = {entry_r[WIDTH-5:0], keycode[3:0]};
                dcount_s = dcount_r + DCW'(1);
            end else begin
                entry_s  = entry_r;
            end
        end else if (key_op_s) begin
            pend_op_s = new_op_s;
            entry_s   = {WIDTH{1'b0}};
            dcount_s  = {DCW{1'b0}};
            if (!do_compute_s) begin
                value_s = acc_r;
            end else begin
                case (pend_op_r)
                    OP_NONE: begin
                        acc_s   = entry_r;
                        value_s = entry_r;
                    end
                    OP_ADD: begin
                        acc_s   = sum_s[WIDTH-1:0];
                        value_s = sum_s[WIDTH-1:0];
                        ovf_s   = ovf_r | sum_s[WIDTH];
                    end
                    OP_SUB: begin
                        acc_s   = acc_r - entry_r;
                        value_s = acc_r - entry_r;
                        ovf_s   = ovf_r | (acc_r < entry_r);
                    end
                    OP_MUL: begin
                        mcand_s  = {{WIDTH{1'b0}}, acc_r};
                        mplier_s = entry_r;
                        prod_s   = {(2 * WIDTH){1'b0}};
                        mcount_s = {MCW{1'b0}};
                        busy_s   = 1'b1;
                    end
                    default: begin
                        acc_s   = acc_r;
                    end
                endcase
            end
`ifdef CALC_BACKSPACE_EN
        end else if (key_bs_s && (state_r == ST_ENTER)) begin
            entry_s  = entry_r >> 3'd4;
            value_s  = entry_r >> 3'd4;
            dcount_s = dcount_r - DCW'(1);
`endif
        end else begin
            kd_s = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_r     <= {WIDTH{1'b0}};
            entry_r   <= {WIDTH{1'b0}};
            pend_op_r <= OP_NONE;
            dcount_r  <= {DCW{1'b0}};
            value_r   <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            ovf_r     <= 1'b0;
            kd_r      <= 1'b0;
            mcand_r   <= {(2 * WIDTH){1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            prod_r    <= {(2 * WIDTH){1'b0}};
            mcount_r  <= {MCW{1'b0}};
        end else begin
            acc_r     <= acc_s;
            entry_r   <= entry_s;
            pend_op_r <= pend_op_s;
            dcount_r  <= dcount_s;
            value_r   <= value_s;
            busy_r    <= busy_s;
            ovf_r     <= ovf_s;
            kd_r      <= kd_s;
            mcand_r   <= mcand_s;
            mplier_r  <= mplier_s;
            prod_r    <= prod_s;
            mcount_r  <= mcount_s;
        end
    end

endmodule

// File: tb/tb_calc_logic_param.sv
// Self-checking bench for calc_logic_param (WIDTH=16): vector table, busy-time corner cases,
// and random key streams against a key-level behavioural model.
module tb_calc_logic_param;
    localparam logic [4:0] K_ADD = 5'h10;
    localparam logic [4:0] K_SUB = 5'h11;
    localparam logic [4:0] K_MUL = 5'h12;
    localparam logic [4:0] K_EQ  = 5'h13;
    localparam logic [4:0] K_CLR = 5'h14;
    localparam logic [4:0] K_BS  = 5'h15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  keycode = 5'h00;
    logic        newkey = 1'b0;
    logic [15:0] value;
    logic        busy, overflow, key_dropped;

    int tests = 0;
    int fails = 0;

    calc_logic_param #(.WIDTH(16)) dut (
        .clock(clock), .reset(reset), .keycode(keycode), .newkey(newkey),
        .value(value), .busy(busy), .overflow(overflow), .key_dropped(key_dropped)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  key;
        logic [15:0] val;
        logic        ovf;
        int          bcyc;
    } vec_t;
    vec_t vecs[$];

    // Key-level reference model.
    longint m_acc, m_entry, m_value;
    int     m_pend, m_dcount;
    bit     m_enter, m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [4:0] k, input logic [15:0] v, input logic o, input int b);
        vec_t r;
        r.key = k; r.val = v; r.ovf = o; r.bcyc = b;
        vecs.push_back(r);
    endtask

    task automatic drive_key(input logic [4:0] k);
        @(negedge clock);
        keycode = k;
        newkey  = 1'b1;
        @(negedge clock);
        newkey  = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 64) begin
            cycles++;
            @(negedge clock);
        end
    endtask

    task automatic press(input logic [4:0] k, output int cycles);
        drive_key(k);
        wait_idle(cycles);
    endtask

    task automatic model_reset();
        m_acc = 0; m_entry = 0; m_value = 0; m_pend = 0; m_dcount = 0; m_enter = 0; m_ovf = 0;
    endtask

    task automatic model_key(input logic [4:0] k, output int exp_busy);
        longint r;
        int     newop;
        bit     comp;
        exp_busy = 0;
        if (k == K_CLR) begin
            model_reset();
        end else if (k < 5'h10) begin
            if (!m_enter) begin
                m_entry = longint'(k); m_dcount = 1; m_enter = 1; m_value = m_entry;
            end else if (m_dcount < 4) begin
                m_entry = m_entry * 16 + longint'(k); m_dcount++; m_value = m_entry;
            end
        end else if (k <= K_EQ) begin
            newop = (k == K_ADD) ? 1 : (k == K_SUB) ? 2 : (k == K_MUL) ? 3 : 0;
            comp  = m_enter || (k == K_EQ && m_pend != 0);
            if (comp) begin
                case (m_pend)
                    0:       r = m_entry;
                    1:       r = m_acc + m_entry;
                    2:       r = m_acc - m_entry;
                    default: begin r = m_acc * m_entry; exp_busy = 16; end
                endcase
                if (r > 65535 || r < 0) m_ovf = 1;
                m_acc = r & 64'hFFFF;
            end
            m_value = m_acc; m_pend = newop; m_entry = 0; m_dcount = 0; m_enter = 0;
        end else if (k == K_BS) begin
`ifdef CALC_BACKSPACE_EN
            if (m_enter) begin
                m_entry = m_entry / 16; m_dcount--; m_value = m_entry;
                if (m_dcount == 0) m_enter = 0;
            end
`endif
        end
    endtask

    initial begin
        int b;
        int eb;
        int sel;
        logic [4:0] k;

        // Test-plan vectors: key, expected value, overflow, busy cycles.
        add_vec(5'h1, 16'h0001, 1'b0, 0);  add_vec(5'h2, 16'h0012, 1'b0, 0);
        add_vec(K_ADD, 16'h0012, 1'b0, 0); add_vec(5'h3, 16'h0003, 1'b0, 0);
        add_vec(5'h4, 16'h0034, 1'b0, 0);  add_vec(K_EQ, 16'h0046, 1'b0, 0);
        add_vec(5'h3, 16'h0003, 1'b0, 0);  add_vec(K_SUB, 16'h0003, 1'b0, 0);
        add_vec(5'h5, 16'h0005, 1'b0, 0);  add_vec(K_EQ, 16'hFFFE, 1'b1, 0);
        add_vec(K_CLR, 16'h0000, 1'b0, 0);
        add_vec(5'h1, 16'h0001, 1'b0, 0);  add_vec(5'h0, 16'h0010, 1'b0, 0);
        add_vec(5'h0, 16'h0100, 1'b0, 0);  add_vec(K_MUL, 16'h0100, 1'b0, 0);
        add_vec(5'h1, 16'h0001, 1'b0, 0);  add_vec(5'h0, 16'h0010, 1'b0, 0);
        add_vec(5'h0, 16'h0100, 1'b0, 0);  add_vec(K_EQ, 16'h0000, 1'b1, 16);
        add_vec(K_CLR, 16'h0000, 1'b0, 0);
        add_vec(5'h1, 16'h0001, 1'b0, 0);  add_vec(5'h2, 16'h0012, 1'b0, 0);
        add_vec(K_MUL, 16'h0012, 1'b0, 0); add_vec(5'h3, 16'h0003, 1'b0, 0);
        add_vec(K_EQ, 16'h0036, 1'b0, 16);
        add_vec(K_CLR, 16'h0000, 1'b0, 0);
        add_vec(5'h1, 16'h0001, 1'b0, 0);  add_vec(5'h2, 16'h0012, 1'b0, 0);
        add_vec(5'h3, 16'h0123, 1'b0, 0);  add_vec(5'h4, 16'h1234, 1'b0, 0);
        add_vec(5'h5, 16'h1234, 1'b0, 0);  add_vec(K_ADD, 16'h1234, 1'b0, 0);
        add_vec(K_ADD, 16'h1234, 1'b0, 0); add_vec(K_SUB, 16'h1234, 1'b0, 0);
        add_vec(5'h6, 16'h0006, 1'b0, 0);  add_vec(K_EQ, 16'h122E, 1'b0, 0);
        add_vec(K_CLR, 16'h0000, 1'b0, 0);
        add_vec(5'hA, 16'h000A, 1'b0, 0);  add_vec(5'hB, 16'h00AB, 1'b0, 0);
        add_vec(5'hC, 16'h0ABC, 1'b0, 0);
`ifdef CALC_BACKSPACE_EN
        add_vec(K_BS, 16'h00AB, 1'b0, 0);  add_vec(K_BS, 16'h000A, 1'b0, 0);
        add_vec(K_BS, 16'h0000, 1'b0, 0);  add_vec(5'h4, 16'h0004, 1'b0, 0);
        add_vec(5'h16, 16'h0004, 1'b0, 0); add_vec(5'h1F, 16'h0004, 1'b0, 0);
`else
        add_vec(K_BS, 16'h0ABC, 1'b0, 0);  add_vec(K_BS, 16'h0ABC, 1'b0, 0);
        add_vec(K_BS, 16'h0ABC, 1'b0, 0);  add_vec(5'h4, 16'hABC4, 1'b0, 0);
        add_vec(5'h16, 16'hABC4, 1'b0, 0); add_vec(5'h1F, 16'hABC4, 1'b0, 0);
`endif

        // Reset state.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset value", 32'(value), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset overflow", 32'(overflow), 32'h0);
        check("reset key_dropped", 32'(key_dropped), 32'h0);

        foreach (vecs[i]) begin
            press(vecs[i].key, b);
            check($sformatf("vec%0d value", i), 32'(value), 32'(vecs[i].val));
            check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            check($sformatf("vec%0d busy cycles", i), 32'(b), 32'(vecs[i].bcyc));
        end

        // Key during multiply is dropped with a single pulse and has no effect.
        press(K_CLR, b); press(5'h1, b); press(5'h2, b); press(K_MUL, b); press(5'h3, b);
        drive_key(K_EQ);
        check("mul busy start", 32'(busy), 32'h1);
        check("mul value held", 32'(value), 32'h0003);
        repeat (3) @(negedge clock);
        drive_key(5'h7);
        check("drop pulse", 32'(key_dropped), 32'h1);
        @(negedge clock);
        check("drop pulse width", 32'(key_dropped), 32'h0);
        wait_idle(b);
        check("drop busy ends", 32'(busy), 32'h0);
        check("drop value", 32'(value), 32'h0036);
        check("drop overflow", 32'(overflow), 32'h0);
        press(K_ADD, b); press(K_EQ, b);
        check("drop entry untouched", 32'(value), 32'h0036);

        // CLEAR during multiply aborts at once and clears overflow.
        press(5'h3, b); press(K_SUB, b); press(5'h5, b); press(K_EQ, b);
        check("pre-clear overflow", 32'(overflow), 32'h1);
        press(5'h2, b); press(K_MUL, b); press(5'h3, b);
        drive_key(K_EQ);
        repeat (4) @(negedge clock);
        drive_key(K_CLR);
        check("clear abort busy", 32'(busy), 32'h0);
        check("clear abort value", 32'(value), 32'h0);
        check("clear abort overflow", 32'(overflow), 32'h0);
        check("clear no drop", 32'(key_dropped), 32'h0);
        repeat (20) @(negedge clock);
        check("clear abort stays idle", 32'({busy, value}), 32'h0);

        // Reset during multiply.
        press(5'h3, b); press(K_SUB, b); press(5'h5, b); press(K_EQ, b);
        press(5'h2, b); press(K_MUL, b); press(5'h3, b);
        drive_key(K_EQ);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("reset abort busy", 32'(busy), 32'h0);
        check("reset abort value", 32'(value), 32'h0);
        check("reset abort overflow", 32'(overflow), 32'h0);
        repeat (20) @(negedge clock);
        check("reset abort stays idle", 32'({busy, value}), 32'h0);

        // Random key stream against the model.
        model_reset();
        press(K_CLR, b);
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 55)      k = 5'($urandom_range(0, 15));
            else if (sel < 85) k = 5'(16 + $urandom_range(0, 3));
            else if (sel < 88) k = K_CLR;
            else if (sel < 94) k = K_BS;
            else               k = 5'($urandom_range(22, 31));
            model_key(k, eb);
            press(k, b);
            check($sformatf("rnd%0d key%0h value", n, k), 32'(value), 32'(m_value));
            check($sformatf("rnd%0d overflow", n), 32'(overflow), 32'(m_ovf));
            check($sformatf("rnd%0d busy cycles", n), 32'(b), 32'(eb));
            check($sformatf("rnd%0d key_dropped", n), 32'(key_dropped), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
